// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for serial_sub.
// The master drives start/operands; the slave returns result, borrow and status.
interface serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;
  logic             done;
  logic             led;

  modport master (
    output start, x, y, bin,
    input  d, bout, busy, done, led
  );

  modport slave (
    input  start, x, y, bin,
    output d, bout, busy, done, led
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor D = X - Y - BIN, one bit per clock, LSB first, with start/busy/done handshake.
// Optional macro SERIAL_SUB_SAT_EN clamps the result to zero whenever the final borrow is set.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic             w_diff;
  logic             w_borrowNext;
  logic             w_last;
  logic [WIDTH-1:0] w_resNext;
  logic             w_busy;
  logic             w_done;

  // Single full-subtractor cell on the current LSBs
  assign w_diff       = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_borrowNext = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
  // The first bit produced only reaches position 0 on the final shift, so r_res needs WIDTH-1 bits
  assign w_resNext    = {w_diff, r_res};
  assign w_last       = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.x;
            r_b      <= bus.y;
            r_borrow <= bus.bin;
            r_res    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrowNext;
          r_res    <= w_resNext[WIDTH-1:1];
          r_cnt    <= r_cnt + CW'(1);
          // Result registers update together with the last bit so they are valid throughout DONE
          if (w_last) begin
            r_bout <= w_borrowNext;
`ifdef SERIAL_SUB_SAT_EN
            r_d    <= w_borrowNext ? '0 : w_resNext;
`else
            r_d    <= w_resNext;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.d    = r_d;
  assign bus.bout = r_bout;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.led  = ~w_busy;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4): vector table, scoreboard queue, and
// hand-written sequences for latency, ignored start, mid-run reset and back-to-back starts.
module tb_serial_sub;
  localparam int WIDTH = 4;
`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       bin;
    logic [3:0] expD;
    logic       expBout;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       bout;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;
  int   errors = 0;
  int   checks = 0;
  int   doneCount = 0;
  bit   monEn = 1'b0;
  exp_t scoreQ[$];
  vec_t vecs[10];

  serial_sub_if #(.WIDTH(WIDTH)) bus();

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t makeVec(logic [3:0] x, logic [3:0] y, logic bin);
    vec_t v;
    v.x       = x;
    v.y       = y;
    v.bin     = bin;
    v.expD    = x - y - {3'b000, bin};
    v.expBout = ({1'b0, x} < ({1'b0, y} + {4'b0000, bin}));
    return v;
  endfunction

  function automatic logic [3:0] satD(logic [3:0] d, logic bout);
    return (SAT && bout) ? 4'h0 : d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one start pulse from a negedge where the DUT is idle; returns on the next negedge.
  task automatic applyStimulus(input vec_t v, input bit track);
    exp_t e;
    bus.x     = v.x;
    bus.y     = v.y;
    bus.bin   = v.bin;
    bus.start = 1'b1;
    if (track) begin
      e.d    = satD(v.expD, v.expBout);
      e.bout = v.expBout;
      scoreQ.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = 4'($urandom_range(0, 15));
    bus.y     = 4'($urandom_range(0, 15));
    bus.bin   = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone();
    int cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) checkOutput("doneTimeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_d"},    32'(bus.d),    32'd0);
    checkOutput({tag, "_bout"}, 32'(bus.bout), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_led"},  32'(bus.led),  32'd1);
  endtask

  // Scoreboard side: every done pulse pops one expected result; led must mirror ~busy
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("ledNotBusy", 32'(bus.led), bus.busy ? 32'd0 : 32'd1);
      if (bus.done) begin
        doneCount++;
        if (scoreQ.size() == 0) begin
          checkOutput("unexpectedDone", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = scoreQ.pop_front();
          checkOutput("resultD",    32'(bus.d),    32'(e.d));
          checkOutput("resultBout", 32'(bus.bout), 32'(e.bout));
        end
      end
    end
  end

  initial begin
    int busyCnt;
    int doneAt;
    int prevDone;
    vec_t v;

    vecs[0] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    vecs[1] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[2] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0};
    vecs[3] = '{4'h7, 4'h2, 1'b1, 4'h4, 1'b0};
    vecs[4] = '{4'h8, 4'h8, 1'b1, 4'hF, 1'b1};
    vecs[5] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1};
    vecs[6] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
    for (int i = 7; i < 10; i++)
      vecs[i] = makeVec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    rstN      = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    monEn = 1'b1;
    checkResetState("reset");
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] first operation 9-3 with latency check");
    applyStimulus('{4'h9, 4'h3, 1'b0, 4'h6, 1'b0}, 1'b1);
    busyCnt = 0;
    doneAt  = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.busy) busyCnt++;
      if (bus.done && doneAt == 0) doneAt = c;
      if (c < 8) @(negedge clk);
    end
    checkOutput("startToDone", 32'(doneAt), 32'd5);
    checkOutput("busyCycles",  32'(busyCnt), 32'd5);

    $display("[TB] reset during RUN");
    applyStimulus('{4'h9, 4'h3, 1'b0, 4'h6, 1'b0}, 1'b0);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkResetState("midRunReset");
    rstN = 1'b1;
    prevDone = doneCount;
    repeat (10) @(negedge clk);
    checkOutput("noDoneAfterReset", 32'(doneCount), 32'(prevDone));
    applyStimulus('{4'h5, 4'h2, 1'b0, 4'h3, 1'b0}, 1'b1);
    waitDone();

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], 1'b1);
      waitDone();
    end

    $display("[TB] start during RUN is ignored");
    applyStimulus('{4'h9, 4'h3, 1'b0, 4'h6, 1'b0}, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 4'h1;
    bus.y     = 4'h1;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone();
    applyStimulus('{4'h1, 4'h1, 1'b0, 4'h0, 1'b0}, 1'b1);
    waitDone();

    $display("[TB] back-to-back with start held high");
    prevDone = doneCount;
    for (int i = 0; i < 36; i++) begin
      checkOutput("b2bBusy", 32'(bus.busy), (i % 6 != 0) ? 32'd1 : 32'd0);
      checkOutput("b2bDone", 32'(bus.done), (i % 6 == 5) ? 32'd1 : 32'd0);
      v = makeVec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      bus.x     = v.x;
      bus.y     = v.y;
      bus.bin   = v.bin;
      bus.start = 1'b1;
      if (i % 6 == 0) scoreQ.push_back('{satD(v.expD, v.expBout), v.expBout});
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2bDoneCount", 32'(doneCount - prevDone), 32'd6);
    checkOutput("queueEmpty",   32'(scoreQ.size()), 32'd0);

    monEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
